// File: rtl/axi4lite_mem_slave.sv
// rtl/axi4lite_mem_slave.sv - AXI4-Lite slave fronting a byte-strobed, zero-based word memory.
// Independent AW/W holding entries, one outstanding write, one outstanding read.
module axi4lite_mem_slave #(
  parameter int N     = 4,
  parameter int I     = 1,
  parameter int DEPTH = 256
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic [31:0]    AWADDR,
  input  logic [2:0]     AWPROT,
  input  logic           WVALID,
  output logic           WREADY,
  input  logic [8*N-1:0] WDATA,
  input  logic [N-1:0]   WSTRB,
  output logic           BVALID,
  input  logic           BREADY,
  output logic [1:0]     BRESP,
  input  logic           ARVALID,
  output logic           ARREADY,
  input  logic [31:0]    ARADDR,
  input  logic [2:0]     ARPROT,
  output logic           RVALID,
  input  logic           RREADY,
  output logic [8*N-1:0] RDATA,
  output logic [1:0]     RRESP
);
  localparam int          AL    = $clog2(N);
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH * N);
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic [8*N-1:0] mem [DEPTH];

  logic           ready_en;
  logic           aw_held;
  logic           aw_ok;
  logic [IW-1:0]  aw_idx;
  logic           w_held;
  logic [8*N-1:0] w_data;
  logic [N-1:0]   w_strb;
  logic           bvalid_q;
  logic [1:0]     bresp_q;
  logic           rvalid_q;
  logic [1:0]     rresp_q;
  logic [8*N-1:0] rdata_q;

  logic           aw_hs;
  logic           w_hs;
  logic           ar_hs;
  logic           commit;
  logic           ar_ok;
  logic [IW-1:0]  ar_idx;

  logic [I-1:0]   unused_id;
  logic           unused_sig;
  assign unused_id  = '0;
  assign unused_sig = ^{AWPROT, ARPROT, unused_id};

  // ready_en keeps every READY low until the first edge after reset release
  assign AWREADY = ready_en & ~aw_held & ~bvalid_q;
  assign WREADY  = ready_en & ~w_held & ~bvalid_q;
  assign ARREADY = ready_en & ~rvalid_q;

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign commit = aw_held & w_held;

  assign ar_ok  = ({1'b0, ARADDR} < LIMIT);
  assign ar_idx = ARADDR[AL +: IW];

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RRESP  = rresp_q;
  assign RDATA  = rdata_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      aw_ok    <= 1'b0;
      aw_idx   <= '0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_ok   <= ({1'b0, AWADDR} < LIMIT);
        aw_idx  <= AWADDR[AL +: IW];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= aw_ok ? OKAY : SLVERR;
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Memory is written only at commit; a read sampled on the same edge sees old data
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && aw_ok) begin
      for (int k = 0; k < N; k++) begin
        if (w_strb[k]) mem[aw_idx][8*k +: 8] <= w_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= ar_ok ? OKAY : SLVERR;
      rdata_q  <= ar_ok ? mem[ar_idx] : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// tb/tb_axi4lite_mem_slave.sv - directed self-checking bench for axi4lite_mem_slave.
module tb_axi4lite_mem_slave;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  int checks   = 0;
  int failures = 0;
  int b_rises  = 0;
  logic bv_prev = 1'b0;

  logic [31:0] rd;
  logic [1:0]  rr;
  logic [1:0]  br;

  axi4lite_mem_slave #(.N(4), .I(1), .DEPTH(256)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (BVALID && !bv_prev) b_rises++;
    bv_prev = BVALID;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, early, ok;
    int cyc, n, rises0;
    rises0 = b_rises;
    aw_done = 0; w_done = 0; aw_hs = 0; w_hs = 0; early = 0; cyc = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge ACLK);
      if (aw_hs) begin aw_done = 1; AWVALID = 0; end
      if (w_hs)  begin w_done = 1;  WVALID = 0;  end
      if (BVALID && !(aw_done && w_done)) early = 1;
      if (!aw_done && cyc >= aw_dly) AWVALID = 1;
      if (!w_done && cyc >= w_dly) WVALID = 1;
      #1;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      cyc++;
    end
    check("wr_accept", {aw_done, w_done}, 2'b11);
    check("wr_no_early_b", early, 1'b0);
    n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    check("wr_bvalid", BVALID, 1'b1);
    resp = BRESP;
    ok = 1;
    repeat (b_dly) begin
      @(negedge ACLK);
      if (!BVALID || BRESP !== resp || AWREADY || WREADY) ok = 0;
    end
    if (b_dly > 0) check("wr_b_stall_stable", ok, 1'b1);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    repeat (3) @(negedge ACLK);
    check("wr_one_b_pulse", b_rises - rises0, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    int n;
    bit ok;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    @(negedge ACLK);
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
    check("rd_rvalid", RVALID, 1'b1);
    data = RDATA; resp = RRESP;
    ok = 1;
    repeat (r_dly) begin
      @(negedge ACLK);
      if (!RVALID || RDATA !== data || RRESP !== resp || ARREADY) ok = 0;
    end
    if (r_dly > 0) check("rd_r_stall_stable", ok, 1'b1);
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    #1 check("rd_released", RVALID, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESETn = 0;
    AWVALID = 0; AWADDR = '0; AWPROT = '0;
    WVALID = 0; WDATA = '0; WSTRB = '0; BREADY = 0;
    ARVALID = 0; ARADDR = '0; ARPROT = '0; RREADY = 0;
    repeat (3) @(negedge ACLK);
    check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("rst_valids", {BVALID, RVALID}, 2'b00);
    check("rst_resps", {BRESP, RRESP}, 4'b0000);
    check("rst_rdata", RDATA, 32'h0);
    ARESETn = 1;
    #1 check("ready_low_at_release", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(negedge ACLK);
    check("ready_after_first_clk", {AWREADY, WREADY, ARREADY}, 3'b111);

    // strobed write, then readback
    do_write(32'h100, 32'h12345678, 4'b1011, 0, 0, 0, br);
    check("w100_bresp", br, 2'b00);
    do_read(32'h100, 0, rd, rr);
    check("r100_data", rd, 32'h12005678);
    check("r100_resp", rr, 2'b00);

    // out-of-range write and read
    do_write(32'h12345678, 32'h0000ABCD, 4'b1111, 0, 0, 0, br);
    check("woor_bresp", br, 2'b10);
    do_read(32'h12345678, 0, rd, rr);
    check("roor_data", rd, 32'h0);
    check("roor_resp", rr, 2'b10);
    do_read(32'h678, 0, rd, rr);
    check("alias_678_untouched", rd, 32'h0);
    do_read(32'h103, 0, rd, rr);
    check("unaligned_103", rd, 32'h12005678);

    // top word in range, first word beyond range
    do_write(32'h3FC, 32'hDEADBEEF, 4'b1111, 0, 0, 0, br);
    check("w3fc_bresp", br, 2'b00);
    do_read(32'h3FC, 0, rd, rr);
    check("r3fc_data", rd, 32'hDEADBEEF);
    do_write(32'h400, 32'h5A5A5A5A, 4'b1111, 0, 0, 0, br);
    check("w400_bresp", br, 2'b10);
    do_read(32'h400, 0, rd, rr);
    check("r400_resp", rr, 2'b10);
    do_read(32'h0, 0, rd, rr);
    check("r0_not_aliased", rd, 32'h0);

    // W two cycles ahead of AW, then AW ahead of W
    do_write(32'h200, 32'hCAFEF00D, 4'b1111, 2, 0, 0, br);
    check("wfirst_bresp", br, 2'b00);
    do_read(32'h200, 0, rd, rr);
    check("wfirst_data", rd, 32'hCAFEF00D);
    do_write(32'h204, 32'h0BADCAFE, 4'b1111, 0, 2, 0, br);
    do_read(32'h204, 0, rd, rr);
    check("awfirst_data", rd, 32'h0BADCAFE);
    do_write(32'h200, 32'h11223344, 4'b0100, 0, 0, 0, br);
    do_read(32'h200, 0, rd, rr);
    check("lane2_only", rd, 32'hCA22F00D);

    // response back-pressure
    do_write(32'h208, 32'h55AA55AA, 4'b1111, 0, 0, 5, br);
    check("stall_bresp", br, 2'b00);
    do_read(32'h208, 5, rd, rr);
    check("stall_rdata", rd, 32'h55AA55AA);

    // read handshake on the same edge as the write commit to word 0x10
    do_write(32'h40, 32'hAAAA5555, 4'b1111, 0, 0, 0, br);
    @(negedge ACLK);
    AWADDR = 32'h40; WDATA = 32'h11112222; WSTRB = 4'b1111; AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    ARADDR = 32'h40; ARVALID = 1;
    @(negedge ACLK);
    ARVALID = 0;
    check("same_edge_valids", {BVALID, RVALID}, 2'b11);
    check("same_edge_old_data", RDATA, 32'hAAAA5555);
    BREADY = 1; RREADY = 1;
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    do_read(32'h40, 0, rd, rr);
    check("same_edge_new_data", rd, 32'h11112222);

    // asynchronous reset while a write response is pending
    @(negedge ACLK);
    AWADDR = 32'h100; WDATA = 32'hFFFFFFFF; WSTRB = 4'b1111; AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    check("pre_reset_bvalid", BVALID, 1'b1);
    #2 ARESETn = 0;
    #1 check("async_drop_bvalid", BVALID, 1'b0);
    @(negedge ACLK);
    ARESETn = 1;
    @(negedge ACLK);
    do_read(32'h100, 0, rd, rr);
    check("post_reset_cleared", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
